// File: rtl/uart_response_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_response_arbiter_if : ASC/STL response streams, UART TX stream, status
// Revision: 1.0
// ============================================================================
interface uart_response_arbiter_if;
  logic       asc_valid;
  logic       asc_ready;
  logic [7:0] asc_data;
  logic       asc_last;
  logic       stl_valid;
  logic       stl_ready;
  logic [7:0] stl_data;
  logic       stl_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       timeout_pulse;

  // Environment side: response producers plus the UART transmitter.
  modport master (
    output asc_valid, asc_data, asc_last,
    output stl_valid, stl_data, stl_last,
    output tx_ready,
    input  asc_ready, stl_ready,
    input  tx_valid, tx_data,
    input  grant, timeout_pulse
  );

  // Arbiter side.
  modport slave (
    input  asc_valid, asc_data, asc_last,
    input  stl_valid, stl_data, stl_last,
    input  tx_ready,
    output asc_ready, stl_ready,
    output tx_valid, tx_data,
    output grant, timeout_pulse
  );
endinterface
`default_nettype wire

// File: rtl/uart_response_arbiter.sv
`default_nettype none
// ============================================================================
// uart_response_arbiter : packet-granular round-robin ASC/STL -> UART TX mux
// Optional tag prefix per packet when ARB_PREFIX_EN is defined.
// Revision: 1.0
// ============================================================================
module uart_response_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter logic [7:0]  ASC_TAG        = 8'h61,
  parameter logic [7:0]  STL_TAG        = 8'h73
) (
  input wire clk,
  input wire n_reset,
  uart_response_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREFIX = 2'd1,
    S_STREAM = 2'd2
  } state_t;

`ifdef ARB_PREFIX_EN
  localparam state_t c_grant_state = S_PREFIX;
`else
  localparam state_t c_grant_state = S_STREAM;
`endif

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_q, rr_d;       // 0: ASC wins a tie, 1: STL wins a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       hold_q, hold_d;

  logic       w_sel_valid;
  logic [7:0] w_sel_data;
  logic       w_sel_last;
  logic       w_pick_stl;
  logic       w_tx_valid;
  logic [7:0] w_tx_data;
  logic       w_asc_ready;
  logic       w_stl_ready;

  assign w_sel_valid = (grant_q[0] & bus.asc_valid) | (grant_q[1] & bus.stl_valid);
  assign w_sel_data  = grant_q[1] ? bus.stl_data : bus.asc_data;
  assign w_sel_last  = grant_q[1] ? bus.stl_last : bus.asc_last;
  assign w_pick_stl  = (bus.asc_valid & bus.stl_valid) ? rr_q : bus.stl_valid;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    pulse_d     = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_data   = hold_q;
    w_asc_ready = 1'b0;
    w_stl_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.asc_valid || bus.stl_valid) begin
          // The pointer always moves past whoever was just served.
          grant_d = w_pick_stl ? 2'b10 : 2'b01;
          rr_d    = ~w_pick_stl;
          state_d = c_grant_state;
        end
      end

      S_PREFIX: begin
        w_tx_valid = 1'b1;
        w_tx_data  = grant_q[1] ? STL_TAG : ASC_TAG;
        if (bus.tx_ready) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end

      S_STREAM: begin
        w_tx_valid  = w_sel_valid;
        w_tx_data   = w_sel_valid ? w_sel_data : hold_q;
        w_asc_ready = grant_q[0] & bus.tx_ready;
        w_stl_ready = grant_q[1] & bus.tx_ready;
        if (w_sel_valid && bus.tx_ready) begin
          cnt_d = '0;
          if (w_sel_last) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end else if (!w_sel_valid) begin
          // Only source silence counts; a stalled transmitter never does.
          if (cnt_q >= c_tmo_last) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
    endcase

    hold_d = w_tx_valid ? w_tx_data : hold_q;
  end

  assign bus.tx_valid      = w_tx_valid;
  assign bus.tx_data       = w_tx_data;
  assign bus.asc_ready     = w_asc_ready;
  assign bus.stl_ready     = w_stl_ready;
  assign bus.grant         = grant_q;
  assign bus.timeout_pulse = pulse_q;

endmodule
`default_nettype wire
